// File: rtl/tick_sample_fifo.sv
// Turns each rising edge of the divided sample clock into a one-cycle strobe and
// captures the sample word into a show-ahead FIFO drained over valid/ready.
module tick_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_div_in,
    input  logic                     enable,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        sample_in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     tick_o,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              prev_div;
    logic              tick;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

    assign tick      = clk_div_in & ~prev_div & enable;
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign full      = (level == LVL_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the tick.
    assign wr_en     = tick & ~clr & (~full | pop);
    assign drop      = tick & ~clr & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_div <= 1'b0;
            tick_o   <= 1'b0;
        end else begin
            prev_div <= clk_div_in;
            tick_o   <= tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_in;
    end

endmodule

// File: doc/tick_sample_fifo.md
Name: tick_sample_fifo

Overview:
- Downstream consumer of the divided sample clock (clk_0, period 20 clk cycles, same clk domain).
- Turns each rising edge of the divided clock into a single-cycle sample strobe.
- Captures the ADC/correlator input word on that strobe into a small FIFO.
- Presents captured words to the DSP core over a valid/ready handshake, with overflow accounting.

Parameters:
DATA_W, 16, sample word width
DEPTH, 8, FIFO depth in words; power of two, minimum 2
CNT_W, 8, width of saturating drop counter

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
clk_div_in  in  1  divided clock from the divider stage, synchronous to clk
enable  in  1  capture enable; ticks ignored while low
clr  in  1  synchronous flush/clear
sample_in  in  DATA_W  sample word, sampled on tick
out_data  out  DATA_W  head-of-FIFO word
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data when out_valid & out_ready
tick_o  out  1  registered one-cycle strobe per detected tick
level  out  $clog2(DEPTH)+1  words held, 0..DEPTH
overflow  out  1  sticky: a tick was dropped because the FIFO was full
drop_cnt  out  CNT_W  saturating count of dropped ticks

Behaviour:
- Reset (rst_n low, async): prev_div=0, tick_o=0, wr_ptr=rd_ptr=0, level=0, out_valid=0, overflow=0, drop_cnt=0. out_data is don't-care while out_valid=0. FIFO memory is not reset.
- Edge detect: prev_div <= clk_div_in every cycle, including while enable is low.
  - tick = clk_div_in & ~prev_div & enable (combinational).
  - Level-high input never re-ticks.
  - An input high out of reset ticks on the first cycle only.
- tick_o is tick delayed by one register: exactly one cycle high per accepted or dropped tick.
- Write: on the posedge where tick=1, sample_in at that edge is written to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Read: pop occurs when out_valid & out_ready; rd_ptr increments modulo DEPTH.
- Show-ahead FIFO: out_data = mem[rd_ptr], out_valid = (level != 0).
  - Write-to-out_valid latency is 1 cycle.
  - No same-cycle bypass when empty.
- Level update: +1 on write only, −1 on read only, unchanged on both.
- Full (level == DEPTH) with tick:
  - If a pop happens in the same cycle: the write is accepted and level stays DEPTH.
  - Otherwise: the sample is dropped, pointers are unchanged, overflow <= 1, and drop_cnt increments, saturating at 2^CNT_W−1.
- Empty with out_ready high: no pop, no pointer change.
- clr (synchronous) has highest priority.
  - Clears: pointers, level, overflow, drop_cnt.
  - A tick in the clr cycle is discarded, and drop_cnt does not count it.
  - tick_o still pulses for that tick.
  - prev_div still updates.
- Reset mid-stream: everything is flushed immediately. The first tick after release needs a fresh rising edge, unless clk_div_in is already high at release (the first-cycle rule above applies).
- Pointer wrap: ptr width is $clog2(DEPTH). Wrap from DEPTH−1 to 0 must not disturb level.

Test Plan:
- Drive clk_div_in from the divider pattern (10 low / 10 high), enable=1, out_ready=1, sample_in = cycle count. Expect one tick_o pulse per 20 clk. Each out_data equals sample_in at its rising-edge cycle. out_valid is high for 1 cycle per word. level never exceeds 1.
- out_ready=0 for 9 ticks, DEPTH=8. Expect level=8 after 8 ticks. The 9th tick sets overflow=1 and drop_cnt=1. Then release out_ready: 8 words drain in capture order, and the 9th sample is absent.
- Hold full, then assert out_ready exactly on a tick cycle. Expect the write accepted, level stays 8, and overflow unchanged.
- enable=0 across 3 divider edges, then enable=1 mid-high phase. Expect no tick until the next genuine rising edge, and no extra word.
- Assert clr on a tick cycle with level=5 and drop_cnt=3. Expect level=0, out_valid=0, overflow=0, drop_cnt=0 next cycle, the tick's sample discarded, and tick_o pulsing once.
- Force 300 drops with CNT_W=8. Expect drop_cnt to saturate at 255. Pulse rst_n low asynchronously mid-cycle. Expect all outputs at reset values immediately, without waiting for a clock edge.
